// File: rtl/pac_motion.sv
// rtl/pac_motion.sv - Pac-Man movement, chasing ghost, capture detection and game state.
module pac_motion #(
    parameter int TICK_DIV   = 833333,
    parameter int PAC_STEP   = 2,
    parameter int GHOST_STEP = 1,
    parameter int PAC_X0     = 304,
    parameter int PAC_Y0     = 224,
    parameter int GHOST_X0   = 0,
    parameter int GHOST_Y0   = 0,
    parameter int X_MAX      = 608,
    parameter int Y_MAX      = 448,
    parameter int COLL       = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] dir,
    input  logic       start,
    output logic [9:0] PacX,
    output logic [8:0] PacY,
    output logic [1:0] state,
    output logic [9:0] GhostX,
    output logic [8:0] GhostY,
    output logic [1:0] game_st,
    output logic       tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    localparam logic [1:0] GS_IDLE   = 2'b00;
    localparam logic [1:0] GS_PLAY   = 2'b01;
    localparam logic [1:0] GS_CAUGHT = 2'b10;

    localparam logic [1:0] FACE_DOWN  = 2'b00;
    localparam logic [1:0] FACE_UP    = 2'b01;
    localparam logic [1:0] FACE_RIGHT = 2'b10;
    localparam logic [1:0] FACE_LEFT  = 2'b11;

    localparam logic signed [11:0] PAC_DX = 12'(PAC_STEP);
    localparam logic signed [11:0] X_LIM  = 12'(X_MAX);
    localparam logic signed [10:0] PAC_DY = 11'(PAC_STEP);
    localparam logic signed [10:0] Y_LIM  = 11'(Y_MAX);
    localparam logic [10:0] G_STEP = 11'(GHOST_STEP);
    localparam logic [10:0] COLL_D = 11'(COLL);

    localparam logic [9:0] PAC_X_RST   = 10'(PAC_X0);
    localparam logic [8:0] PAC_Y_RST   = 9'(PAC_Y0);
    localparam logic [9:0] GHOST_X_RST = 10'(GHOST_X0);
    localparam logic [8:0] GHOST_Y_RST = 9'(GHOST_Y0);

    function automatic logic [10:0] abs11(input logic [10:0] v);
        return v[10] ? (~v + 11'd1) : v;
    endfunction

    logic [CW-1:0] tick_cnt;
    logic [CW-1:0] cnt_next;

    assign cnt_next = (tick_cnt == CNT_LAST) ? '0 : tick_cnt + 1'b1;

    // tick is registered against the counter's next value so it is high exactly while tick_cnt == TICK_DIV-1
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            tick_cnt <= cnt_next;
            tick     <= (cnt_next == CNT_LAST);
        end
    end

    logic [1:0] heading;
    always_comb begin
        heading = state;
        if (dir[3])      heading = FACE_UP;
        else if (dir[2]) heading = FACE_DOWN;
        else if (dir[1]) heading = FACE_LEFT;
        else if (dir[0]) heading = FACE_RIGHT;
    end

    logic signed [11:0] pac_x_w;
    logic signed [10:0] pac_y_w;
    logic [9:0] pac_x_nx;
    logic [8:0] pac_y_nx;
    always_comb begin
        pac_x_w = $signed({2'b00, PacX});
        pac_y_w = $signed({2'b00, PacY});
        case (heading)
            FACE_UP:   pac_y_w = pac_y_w - PAC_DY;
            FACE_DOWN: pac_y_w = pac_y_w + PAC_DY;
            FACE_LEFT: pac_x_w = pac_x_w - PAC_DX;
            default:   pac_x_w = pac_x_w + PAC_DX;
        endcase
        if (pac_x_w < 12'sd0)      pac_x_nx = '0;
        else if (pac_x_w > X_LIM)  pac_x_nx = X_LIM[9:0];
        else                       pac_x_nx = pac_x_w[9:0];
        if (pac_y_w < 11'sd0)      pac_y_nx = '0;
        else if (pac_y_w > Y_LIM)  pac_y_nx = Y_LIM[8:0];
        else                       pac_y_nx = pac_y_w[8:0];
    end

    // Ghost chases Pac-Man's pre-tick position along the dominant axis, X winning ties
    logic [10:0] dx, dy, adx, ady;
    logic [9:0]  ghost_x_nx;
    logic [8:0]  ghost_y_nx;
    always_comb begin
        dx = {1'b0, PacX} - {1'b0, GhostX};
        dy = {2'b00, PacY} - {2'b00, GhostY};
        adx = abs11(dx);
        ady = abs11(dy);
        ghost_x_nx = GhostX;
        ghost_y_nx = GhostY;
        if (adx != 11'd0 && adx >= ady) begin
            if (adx < G_STEP)  ghost_x_nx = PacX;
            else if (dx[10])   ghost_x_nx = GhostX - G_STEP[9:0];
            else               ghost_x_nx = GhostX + G_STEP[9:0];
        end else if (ady != 11'd0) begin
            if (ady < G_STEP)  ghost_y_nx = PacY;
            else if (dy[10])   ghost_y_nx = GhostY - G_STEP[8:0];
            else               ghost_y_nx = GhostY + G_STEP[8:0];
        end
    end

    logic [10:0] cdx, cdy;
    logic        caught;
    assign cdx    = abs11({1'b0, pac_x_nx} - {1'b0, ghost_x_nx});
    assign cdy    = abs11({2'b00, pac_y_nx} - {2'b00, ghost_y_nx});
    assign caught = (cdx < COLL_D) && (cdy < COLL_D);

    always_ff @(posedge clk) begin
        if (rst) begin
            PacX    <= PAC_X_RST;
            PacY    <= PAC_Y_RST;
            GhostX  <= GHOST_X_RST;
            GhostY  <= GHOST_Y_RST;
            state   <= FACE_RIGHT;
            game_st <= GS_IDLE;
        end else begin
            case (game_st)
                GS_IDLE, GS_CAUGHT: begin
                    if (start) begin
                        PacX    <= PAC_X_RST;
                        PacY    <= PAC_Y_RST;
                        GhostX  <= GHOST_X_RST;
                        GhostY  <= GHOST_Y_RST;
                        state   <= FACE_RIGHT;
                        game_st <= GS_PLAY;
                    end
                end
                GS_PLAY: begin
                    if (dir != 4'b0000) state <= heading;
                    if (tick) begin
                        PacX   <= pac_x_nx;
                        PacY   <= pac_y_nx;
                        GhostX <= ghost_x_nx;
                        GhostY <= ghost_y_nx;
                        if (caught) game_st <= GS_CAUGHT;
                    end
                end
                default: game_st <= GS_IDLE;
            endcase
        end
    end
endmodule
